// File: rtl/mips_pipeline_top_if.sv
// Retirement trace bundle: what the WB stage hands to a lock-step checker each cycle.
interface mips_pipeline_top_if;
  logic        o_retired;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_reg_write;
  logic [4:0]  o_wr_reg;
  logic [31:0] o_wb_data;
  logic        o_is_r;
  logic        o_is_i;
  logic        o_is_j;

  modport master (output o_retired, o_pc, o_instr, o_reg_write, o_wr_reg, o_wb_data,
                  o_is_r, o_is_i, o_is_j);
  modport slave  (input  o_retired, o_pc, o_instr, o_reg_write, o_wr_reg, o_wb_data,
                  o_is_r, o_is_i, o_is_j);
endinterface

// File: rtl/mips_pipeline_top.sv
// Classic 5-stage in-order MIPS32 integer pipeline (IF, ID, EX, MEM, WB) with
// EX-stage forwarding, ID-stage branch resolution and a retirement trace port.

// Register file: write in first half, read in second half (WB->ID bypass).
module mips_regfile (
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] regfile [0:31];

  // Architectural register write; $0 stays hard-wired to zero
  always_ff @(posedge clk) begin
    if (i_we && i_waddr != 5'd0) regfile[i_waddr] <= i_wdata;
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'h0 : (i_we && i_waddr == i_ra1) ? i_wdata : regfile[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'h0 : (i_we && i_waddr == i_ra2) ? i_wdata : regfile[i_ra2];
endmodule

module mips_pipeline_top #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  mips_pipeline_top_if.master trace
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic [31:0] PC, instrWire, instrWireID, instrWireEX, instrWireMEM, instrWireWB;
  logic [31:0] PC_ID, PC_EX, PC_MEM, PC_WB;
  logic [31:0] readData1EX, r_rd2_ex, r_alu_mem, r_st_mem, r_wb_val;
  logic [31:0] ALUSrc1, w_src2, ALUResult, WBData, w_rf1, w_rf2, w_br1, w_br2;
  logic [31:0] w_pc4_id, w_imm_id, w_target, w_mem_val;
  logic [4:0]  w_rs_id, w_rt_id, w_dest_ex, w_dest_mem, w_dest_wb;
  logic        RegWriteWB, is_r_type_WB, is_i_type_WB, is_j_type_WB, instr_retired;
  logic        dataStall, controlStall, w_taken, w_load_use, w_br_haz;
  logic        w_beq, w_bne, w_j, w_jal, w_jr;

  // Destination register of an instruction; 0 means no architectural write.
  function automatic logic [4:0] f_dest(input logic [5:0] op, input logic [5:0] funct,
                                        input logic [4:0] rt, input logic [4:0] rd);
    f_dest = 5'd0;
    case (op)
      6'h00: if (funct != 6'h08 && funct != 6'h0c) f_dest = rd;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23: f_dest = rt;
      6'h03: f_dest = 5'd31;
      default: f_dest = 5'd0;
    endcase
  endfunction

  function automatic logic f_uses_rs(input logic [5:0] op, input logic [5:0] funct);
    f_uses_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0f ||
                  (op == 6'h00 && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)));
  endfunction

  function automatic logic f_uses_rt(input logic [5:0] op);
    f_uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b);
  endfunction

  function automatic logic [31:0] f_alu(input logic [5:0] op, input logic [5:0] funct,
                                        input logic [4:0] shamt, input logic [15:0] imm,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] pc);
    logic [31:0]        ims, imz;
    logic signed [31:0] sa, sb, sims;
    ims  = {{16{imm[15]}}, imm};
    imz  = {16'h0, imm};
    sa   = a;
    sb   = b;
    sims = ims;
    f_alu = 32'h0;
    case (op)
      6'h00: case (funct)
        6'h00:        f_alu = b << shamt;
        6'h02:        f_alu = b >> shamt;
        6'h03:        f_alu = sb >>> shamt;
        6'h20, 6'h21: f_alu = a + b;
        6'h22, 6'h23: f_alu = a - b;
        6'h24:        f_alu = a & b;
        6'h25:        f_alu = a | b;
        6'h26:        f_alu = a ^ b;
        6'h27:        f_alu = ~(a | b);
        6'h2a:        f_alu = {31'h0, sa < sb};
        6'h2b:        f_alu = {31'h0, a < b};
        default:      f_alu = 32'h0;
      endcase
      6'h08, 6'h09, 6'h23, 6'h2b: f_alu = a + ims;
      6'h0a:   f_alu = {31'h0, sa < sims};
      6'h0b:   f_alu = {31'h0, a < ims};
      6'h0c:   f_alu = a & imz;
      6'h0d:   f_alu = a | imz;
      6'h0e:   f_alu = a ^ imz;
      6'h0f:   f_alu = {imm, 16'h0};
      6'h03:   f_alu = pc + 32'd4;
      default: f_alu = 32'h0;
    endcase
  endfunction

  // ---- IF ----
  assign instrWire = imem[PC[IAW+1:2]];

  // ---- ID: decode, operand read, hazard detection, branch resolution ----
  assign w_rs_id  = instrWireID[25:21];
  assign w_rt_id  = instrWireID[20:16];
  assign w_pc4_id = PC_ID + 32'd4;
  assign w_imm_id = {{16{instrWireID[15]}}, instrWireID[15:0]};

  mips_regfile u11 (
    .clk(clk), .i_we(RegWriteWB), .i_waddr(w_dest_wb), .i_wdata(WBData),
    .i_ra1(w_rs_id), .i_ra2(w_rt_id), .o_rd1(w_rf1), .o_rd2(w_rf2)
  );

  assign w_dest_ex  = f_dest(instrWireEX[31:26], instrWireEX[5:0], instrWireEX[20:16], instrWireEX[15:11]);
  assign w_dest_mem = f_dest(instrWireMEM[31:26], instrWireMEM[5:0], instrWireMEM[20:16], instrWireMEM[15:11]);
  assign w_dest_wb  = f_dest(instrWireWB[31:26], instrWireWB[5:0], instrWireWB[20:16], instrWireWB[15:11]);

  assign w_br1 = (w_dest_mem != 5'd0 && w_dest_mem == w_rs_id) ? r_alu_mem : w_rf1;
  assign w_br2 = (w_dest_mem != 5'd0 && w_dest_mem == w_rt_id) ? r_alu_mem : w_rf2;

  assign w_beq = instrWireID[31:26] == 6'h04;
  assign w_bne = instrWireID[31:26] == 6'h05;
  assign w_j   = instrWireID[31:26] == 6'h02;
  assign w_jal = instrWireID[31:26] == 6'h03;
  assign w_jr  = instrWireID[31:26] == 6'h00 && instrWireID[5:0] == 6'h08;

  assign w_load_use = (instrWireEX[31:26] == 6'h23) && w_dest_ex != 5'd0 &&
                      ((f_uses_rs(instrWireID[31:26], instrWireID[5:0]) && w_rs_id == w_dest_ex) ||
                       (f_uses_rt(instrWireID[31:26]) && w_rt_id == w_dest_ex));
  // A branch/jr operand still being produced in EX (or loaded in MEM) cannot be compared yet.
  assign w_br_haz = ((w_beq || w_bne || w_jr) && w_rs_id != 5'd0 &&
                     (w_rs_id == w_dest_ex || (instrWireMEM[31:26] == 6'h23 && w_rs_id == w_dest_mem))) ||
                    ((w_beq || w_bne) && w_rt_id != 5'd0 &&
                     (w_rt_id == w_dest_ex || (instrWireMEM[31:26] == 6'h23 && w_rt_id == w_dest_mem)));
  assign dataStall    = w_load_use | w_br_haz;
  assign controlStall = w_taken;

  // Resolve taken branches/jumps and their target while ID is not stalled
  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc4_id + (w_imm_id << 2);
    if (!dataStall) begin
      if (w_beq) w_taken = (w_br1 == w_br2);
      if (w_bne) w_taken = (w_br1 != w_br2);
      if (w_j || w_jal) begin
        w_taken  = 1'b1;
        w_target = {w_pc4_id[31:28], instrWireID[25:0], 2'b00};
      end
      if (w_jr) begin
        w_taken  = 1'b1;
        w_target = w_br1;
      end
    end
  end

  // PC and IF/ID: hold on data stall, redirect and squash fetched slot on taken branch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC          <= RESET_PC;
      instrWireID <= 32'h0;
      PC_ID       <= 32'h0;
    end else if (!dataStall) begin
      PC          <= w_taken ? w_target : PC + 32'd4;
      instrWireID <= w_taken ? 32'h0 : instrWire;
      PC_ID       <= w_taken ? 32'h0 : PC;
    end
  end

  // ID/EX: bubble injected while ID is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || dataStall) begin
      instrWireEX <= 32'h0;
      PC_EX       <= 32'h0;
      readData1EX <= 32'h0;
      r_rd2_ex    <= 32'h0;
    end else begin
      instrWireEX <= instrWireID;
      PC_EX       <= PC_ID;
      readData1EX <= w_rf1;
      r_rd2_ex    <= w_rf2;
    end
  end

  // ---- EX: forwarding from EX/MEM then MEM/WB ----
  assign ALUSrc1 = (w_dest_mem != 5'd0 && w_dest_mem == instrWireEX[25:21]) ? r_alu_mem :
                   (w_dest_wb  != 5'd0 && w_dest_wb  == instrWireEX[25:21]) ? WBData : readData1EX;
  assign w_src2  = (w_dest_mem != 5'd0 && w_dest_mem == instrWireEX[20:16]) ? r_alu_mem :
                   (w_dest_wb  != 5'd0 && w_dest_wb  == instrWireEX[20:16]) ? WBData : r_rd2_ex;
  assign ALUResult = f_alu(instrWireEX[31:26], instrWireEX[5:0], instrWireEX[10:6],
                           instrWireEX[15:0], ALUSrc1, w_src2, PC_EX);

  // EX/MEM register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrWireMEM <= 32'h0;
      PC_MEM       <= 32'h0;
      r_alu_mem    <= 32'h0;
      r_st_mem     <= 32'h0;
    end else begin
      instrWireMEM <= instrWireEX;
      PC_MEM       <= PC_EX;
      r_alu_mem    <= ALUResult;
      r_st_mem     <= w_src2;
    end
  end

  // ---- MEM ----
  assign w_mem_val = (instrWireMEM[31:26] == 6'h23) ? dmem[r_alu_mem[DAW+1:2]] : r_alu_mem;

  // Full-word store commits at the end of MEM
  always_ff @(posedge clk) begin
    if (instrWireMEM[31:26] == 6'h2b) dmem[r_alu_mem[DAW+1:2]] <= r_st_mem;
  end

  // MEM/WB register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrWireWB <= 32'h0;
      PC_WB       <= 32'h0;
      r_wb_val    <= 32'h0;
    end else begin
      instrWireWB <= instrWireMEM;
      PC_WB       <= PC_MEM;
      r_wb_val    <= w_mem_val;
    end
  end

  // ---- WB ----
  assign WBData        = r_wb_val;
  assign RegWriteWB    = (w_dest_wb != 5'd0);
  assign instr_retired = (instrWireWB != 32'h0);
  assign is_r_type_WB  = (instrWireWB[31:26] == 6'h00);
  assign is_j_type_WB  = (instrWireWB[31:26] == 6'h02) || (instrWireWB[31:26] == 6'h03);
  assign is_i_type_WB  = !is_r_type_WB && !is_j_type_WB;

  assign trace.o_retired   = instr_retired;
  assign trace.o_pc        = PC_WB;
  assign trace.o_instr     = instrWireWB;
  assign trace.o_reg_write = RegWriteWB;
  assign trace.o_wr_reg    = w_dest_wb;
  assign trace.o_wb_data   = WBData;
  assign trace.o_is_r      = is_r_type_WB;
  assign trace.o_is_i      = is_i_type_WB;
  assign trace.o_is_j      = is_j_type_WB;
endmodule

// File: tb/tb_mips_pipeline_top.sv
// Bench for mips_pipeline_top: preloads a directed program, scoreboards every retirement.
module tb_mips_pipeline_top;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mips_pipeline_top_if trace();
  mips_pipeline_top #(.RESET_PC(32'h0), .IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .trace(trace)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  ty;   // {r,i,j}
  } exp_t;

  exp_t exp_q[$];
  exp_t e_cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   retires = 0;
  int   ds_cnt = 0;
  int   cs_cnt = 0;
  bit   done = 1'b0;
  bit   first_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic ld(input logic [31:0] pc, input logic [31:0] ins);
    dut.imem[pc[11:2]] = ins;
  endtask

  task automatic ex(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd,
                    input logic [31:0] val, input logic [2:0] ty);
    exp_q.push_back('{pc, ins, rd, val, ty});
  endtask

  always @(posedge clk) if (reset) cyc++;

  // Monitor: pops the scoreboard whenever the DUT retires an instruction
  always @(negedge clk) begin
    if (reset && !done) begin
      ds_cnt += int'(dut.dataStall);
      cs_cnt += int'(dut.controlStall);
      if (trace.o_retired) begin
        retires++;
        if (!first_seen) begin
          first_seen = 1'b1;
          chk("first_retire_cycle", cyc, 32'd4);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_retire pc=%h instr=%h required=none", trace.o_pc, trace.o_instr);
        end else begin
          e_cur = exp_q.pop_front();
          chk("retire_pc", trace.o_pc, e_cur.pc);
          chk("retire_instr", trace.o_instr, e_cur.ins);
          chk("retire_type", {29'h0, trace.o_is_r, trace.o_is_i, trace.o_is_j}, {29'h0, e_cur.ty});
          chk("retire_regwrite", {31'h0, trace.o_reg_write}, {31'h0, e_cur.rd != 5'd0});
          if (e_cur.rd != 5'd0) begin
            chk("retire_wr_reg", {27'h0, trace.o_wr_reg}, {27'h0, e_cur.rd});
            chk("retire_wb_data", trace.o_wb_data, e_cur.val);
          end
          if (e_cur.ins == 32'h0000000C) done = 1'b1;
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dut.imem[i] = 32'h0;
      dut.dmem[i] = 32'h0;
    end
    for (int i = 0; i < 32; i++) dut.u11.regfile[i] = 32'h0;
    dut.dmem[0] = 32'h0000_1234;

    ld(32'h00, 32'h24010005); ld(32'h04, 32'h00211021); ld(32'h08, 32'h8C030000);
    ld(32'h0C, 32'h00632021); ld(32'h10, 32'h10000002); ld(32'h14, 32'h24050099);
    ld(32'h18, 32'h24050077); ld(32'h1C, 32'h0C000020); ld(32'h20, 32'hAC040004);
    ld(32'h24, 32'h8C060004); ld(32'h28, 32'h00014023); ld(32'h2C, 32'h00084843);
    ld(32'h30, 32'h0101502A); ld(32'h34, 32'h0101582B); ld(32'h38, 32'h3C0CABCD);
    ld(32'h3C, 32'h398DFFFF); ld(32'h40, 32'h14210005); ld(32'h44, 32'h2402000A);
    ld(32'h48, 32'h0000000C); ld(32'h80, 32'h3407F00F); ld(32'h84, 32'h03E00008);
    ld(32'h88, 32'h24050055);

    // Retirement order with hand-computed results
    ex(32'h00, 32'h24010005, 5'd1,  32'h5,        3'b010);
    ex(32'h04, 32'h00211021, 5'd2,  32'hA,        3'b100);
    ex(32'h08, 32'h8C030000, 5'd3,  32'h1234,     3'b010);
    ex(32'h0C, 32'h00632021, 5'd4,  32'h2468,     3'b100);
    ex(32'h10, 32'h10000002, 5'd0,  32'h0,        3'b010);
    ex(32'h1C, 32'h0C000020, 5'd31, 32'h20,       3'b001);
    ex(32'h80, 32'h3407F00F, 5'd7,  32'hF00F,     3'b010);
    ex(32'h84, 32'h03E00008, 5'd0,  32'h0,        3'b100);
    ex(32'h20, 32'hAC040004, 5'd0,  32'h0,        3'b010);
    ex(32'h24, 32'h8C060004, 5'd6,  32'h2468,     3'b010);
    ex(32'h28, 32'h00014023, 5'd8,  32'hFFFFFFFB, 3'b100);
    ex(32'h2C, 32'h00084843, 5'd9,  32'hFFFFFFFD, 3'b100);
    ex(32'h30, 32'h0101502A, 5'd10, 32'h1,        3'b100);
    ex(32'h34, 32'h0101582B, 5'd11, 32'h0,        3'b100);
    ex(32'h38, 32'h3C0CABCD, 5'd12, 32'hABCD0000, 3'b010);
    ex(32'h3C, 32'h398DFFFF, 5'd13, 32'hABCDFFFF, 3'b010);
    ex(32'h40, 32'h14210005, 5'd0,  32'h0,        3'b010);
    ex(32'h44, 32'h2402000A, 5'd2,  32'hA,        3'b010);
    ex(32'h48, 32'h0000000C, 5'd0,  32'h0,        3'b100);

    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_pc", dut.PC, 32'h0);
    chk("reset_retired", {31'h0, trace.o_retired}, 32'h0);
    chk("reset_pc_wb", trace.o_pc, 32'h0);
    chk("reset_instr_wb", trace.o_instr, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL syscall_timeout retired=%0d required=19", retires);
    end

    chk("retire_count", retires, 32'd19);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("data_stall_cycles", ds_cnt, 32'd1);
    chk("control_stall_cycles", cs_cnt, 32'd3);
    chk("reg0",  dut.u11.regfile[0],  32'h0);
    chk("reg1",  dut.u11.regfile[1],  32'h5);
    chk("reg2",  dut.u11.regfile[2],  32'hA);
    chk("reg3",  dut.u11.regfile[3],  32'h1234);
    chk("reg4",  dut.u11.regfile[4],  32'h2468);
    chk("reg5",  dut.u11.regfile[5],  32'h0);
    chk("reg6",  dut.u11.regfile[6],  32'h2468);
    chk("reg7",  dut.u11.regfile[7],  32'hF00F);
    chk("reg8",  dut.u11.regfile[8],  32'hFFFFFFFB);
    chk("reg9",  dut.u11.regfile[9],  32'hFFFFFFFD);
    chk("reg10", dut.u11.regfile[10], 32'h1);
    chk("reg11", dut.u11.regfile[11], 32'h0);
    chk("reg12", dut.u11.regfile[12], 32'hABCD0000);
    chk("reg13", dut.u11.regfile[13], 32'hABCDFFFF);
    chk("reg31", dut.u11.regfile[31], 32'h20);
    chk("dmem1", dut.dmem[1], 32'h2468);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
